// File: rtl/snoop_bus_controller_pkg.sv
// rtl/snoop_bus_controller_pkg.sv - MSI state and bus message codes shared with the CPU-side cache FSM
package snoop_bus_controller_pkg;

  // MSI line states
  localparam logic [1:0] MSI_I = 2'b00;
  localparam logic [1:0] MSI_E = 2'b01;
  localparam logic [1:0] MSI_S = 2'b10;

  // Bus message codes
  localparam logic [1:0] BUS_RD   = 2'b00;
  localparam logic [1:0] BUS_WR   = 2'b01;
  localparam logic [1:0] BUS_INV  = 2'b10;
  localparam logic [1:0] BUS_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LOOKUP    = 2'b01,
    ST_WRITEBACK = 2'b10,
    ST_UPDATE    = 2'b11
  } snoop_state_e;

  // Line state after a snooped message; an invalid line stays invalid
  function automatic logic [1:0] snoop_next_state(input logic [1:0] msg, input logic [1:0] cur);
    if (msg == BUS_RD && cur != MSI_I) begin
      return MSI_S;
    end
    return MSI_I;
  endfunction

endpackage

// File: rtl/snoop_bus_controller_line_table.sv
// rtl/snoop_bus_controller_line_table.sv - direct-mapped tag/state table with snoop-priority write ports
module msi_line_table
  import snoop_bus_controller_pkg::*;
#(
  parameter int LINES   = 4,
  parameter int INDEX_W = 2,
  parameter int TAG_W   = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [1:0]         rd_state,
  input  logic               snp_we,
  input  logic [INDEX_W-1:0] snp_idx,
  input  logic [1:0]         snp_state,
  input  logic               cpu_we,
  input  logic [INDEX_W-1:0] cpu_idx,
  input  logic [TAG_W-1:0]   cpu_tag,
  input  logic [1:0]         cpu_state
);

  logic [TAG_W-1:0] tag_q   [LINES];
  logic [1:0]       state_q [LINES];
  logic             cpu_blocked;
  logic [1:0]       cpu_state_clean;

  assign rd_tag   = tag_q[rd_idx];
  assign rd_state = state_q[rd_idx];

  // A snoop update to the same index overrides the CPU write entirely
  assign cpu_blocked     = snp_we && (snp_idx == cpu_idx);
  // The unused code 11 is stored as invalid so the table only ever holds I/E/S
  assign cpu_state_clean = (cpu_state == 2'b11) ? MSI_I : cpu_state;

  // Table storage: CPU writes tag+state, snoop writes state only
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]   <= '0;
        state_q[i] <= MSI_I;
      end
    end else begin
      if (cpu_we && !cpu_blocked) begin
        tag_q[cpu_idx]   <= cpu_tag;
        state_q[cpu_idx] <= cpu_state_clean;
      end
      if (snp_we) begin
        state_q[snp_idx] <= snp_state;
      end
    end
  end

endmodule

// File: rtl/snoop_bus_controller.sv
// rtl/snoop_bus_controller.sv - bus-side MSI snoop controller for a direct-mapped cache
module snoop_bus_controller
  import snoop_bus_controller_pkg::*;
#(
  parameter int LINES   = 4,
  parameter int INDEX_W = 2,
  parameter int TAG_W   = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     bus_valid,
  input  logic [1:0]               bus_msg,
  input  logic [TAG_W+INDEX_W-1:0] bus_addr,
  output logic                     snoop_ready,
  input  logic                     cpu_upd,
  input  logic [TAG_W+INDEX_W-1:0] cpu_addr,
  input  logic [1:0]               cpu_state,
  output logic                     wb_valid,
  output logic [TAG_W+INDEX_W-1:0] wb_addr,
  input  logic                     wb_ready,
  output logic                     abort_mem,
  output logic [1:0]               line_state,
  output logic                     proto_err
);

  localparam int AW = TAG_W + INDEX_W;

  snoop_state_e    state_q, state_d;
  logic [1:0]      msg_q, msg_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            proto_err_q, proto_err_d;
  logic [1:0]      line_state_q, line_state_d;

  logic [TAG_W-1:0] rd_tag;
  logic [1:0]       rd_state;
  logic             hit;
  logic             snoop_we;
  logic [1:0]       snoop_state;

  // Lookup and update both address the table with the latched bus address
  msi_line_table #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_table (
    .clock     (clock),
    .reset_n   (reset_n),
    .rd_idx    (addr_q[INDEX_W-1:0]),
    .rd_tag    (rd_tag),
    .rd_state  (rd_state),
    .snp_we    (snoop_we),
    .snp_idx   (addr_q[INDEX_W-1:0]),
    .snp_state (snoop_state),
    .cpu_we    (cpu_upd),
    .cpu_idx   (cpu_addr[INDEX_W-1:0]),
    .cpu_tag   (cpu_addr[AW-1:INDEX_W]),
    .cpu_state (cpu_state)
  );

  assign hit         = (rd_tag == addr_q[AW-1:INDEX_W]) && (rd_state != MSI_I);
  // Rule is applied to whatever the entry holds in UPDATE, even if the CPU changed it meanwhile
  assign snoop_state = snoop_next_state(msg_q, rd_state);

  // State and latched-message registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      msg_q        <= BUS_RD;
      addr_q       <= '0;
      proto_err_q  <= 1'b0;
      line_state_q <= MSI_I;
    end else begin
      state_q      <= state_d;
      msg_q        <= msg_d;
      addr_q       <= addr_d;
      proto_err_q  <= proto_err_d;
      line_state_q <= line_state_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    msg_d        = msg_q;
    addr_d       = addr_q;
    proto_err_d  = proto_err_q;
    line_state_d = line_state_q;
    snoop_we     = 1'b0;
    snoop_ready  = 1'b0;
    wb_valid     = 1'b0;
    abort_mem    = 1'b0;
    wb_addr      = '0;
    case (state_q)
      ST_IDLE: begin
        snoop_ready = 1'b1;
        if (bus_valid && bus_msg != BUS_NONE) begin
          msg_d   = bus_msg;
          addr_d  = bus_addr;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (!hit) begin
          state_d = ST_IDLE;
        end else if (rd_state == MSI_E) begin
          if (msg_q == BUS_INV) begin
            // Another cache claims ownership of a line we hold exclusive
            proto_err_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end else begin
          state_d = ST_UPDATE;
        end
      end
      ST_WRITEBACK: begin
        wb_valid  = 1'b1;
        abort_mem = 1'b1;
        wb_addr   = addr_q;
        if (wb_ready) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        snoop_we     = 1'b1;
        line_state_d = snoop_state;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign proto_err  = proto_err_q;
  assign line_state = line_state_q;

endmodule
